draw_character: RTL and testbench
=================================

Name: draw_character

Overview:
- Rendering stage that overlays the 48x64 player sprite onto the VGA pixel stream.
- Generates the sprite ROM read address and the frame-stable skin select for the character ROM.
- Consumes the ROM's registered 12-bit rgb and delays the VGA timing to match.
- Sits between the background/level draw stage (upstream) and the VGA output register (downstream).

Parameters:
- CHAR_W, 48, sprite width in pixels.
- CHAR_H, 64, sprite height in pixels; CHAR_W*CHAR_H must be 3072 or less.
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through.
- BBOX_RGB, 12'hFFF, bounding-box colour, used only with the optional feature.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- xpos  in  11  sprite top-left x, screen pixels
- ypos  in  11  sprite top-left y, screen pixels
- skin_in  in  3  requested skin code (0 idle, 1 prep, 2 jump, 3 left, 4 right)
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical pixel counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing
- rgb_in  in  12  background pixel
- rom_rgb  in  12  ROM data, valid 1 clk after rom_address
- rom_address  out  12  sprite ROM address
- character_skin  out  3  skin select to the ROM
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel

Behaviour:
- Reset (rst_n low, asynchronous): every output, latch and pipeline register goes to 0.
- Frame latch:
  - When hcount_in==0 and vcount_in==0, register xpos, ypos and skin_in into x_l, y_l, skin_l.
  - Mid-frame changes to these inputs have no effect until the next frame.
  - Out of reset, x_l, y_l and skin_l are 0 until the first latch.
- character_skin = skin_l (registered).
  - Codes 5–7 pass through unchanged; the ROM applies its default.
- Stage 1 (clock edge after inputs):
  - dx = hcount_in - x_l and dy = vcount_in - y_l, 11-bit unsigned.
  - in_box = (hcount_in >= x_l) && (hcount_in < x_l+CHAR_W) && (vcount_in >= y_l) && (vcount_in < y_l+CHAR_H), compared at 12 bits so the sum cannot wrap.
  - rom_address <= in_box ? dy*CHAR_W + dx : 0, truncated to 12 bits. With defaults this is dy*32 + dy*16 + dx, so no multiplier is needed.
  - Delay timing, counters, rgb_in and in_box by one stage.
- Stage 2: ROM returns rom_rgb; delay all stage-1 signals one more stage.
- Stage 3 (output register): rgb_out <= (in_box_d2 && rom_rgb != TRANSPARENT && !hblnk_d2 && !vblnk_d2) ? rom_rgb : rgb_d2.
- Latency:
  - Every *_out equals the matching *_in exactly 3 clk earlier.
  - rom_address lags its input pixel by 1 clk.
  - Timing passes through unmodified.
- Edge cases:
  - Sprite partly off-screen (x_l > 640-CHAR_W): only the visible columns draw, and addresses stay under 3072.
  - x_l or y_l ≥ 2048-CHAR_W: the 12-bit compare must not wrap, so nothing is drawn.
  - Blanking always outputs rgb_d2, which must be 0 when upstream blanks.
- Reset mid-frame: the pipeline flushes to 0 immediately. Valid output resumes 3 clk after rst_n rises with the stream. Position is 0 until the next frame latch.

Optional Feature:
- Macro DRAW_CHAR_BBOX_EN.
- Defined: pixels on the sprite rectangle perimeter (dx==0, dx==CHAR_W-1, dy==0 or dy==CHAR_H-1, inside in_box) output BBOX_RGB. This overrides both sprite and transparency, but not blanking.
- Undefined: no perimeter logic; the stage-3 rule applies unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release rst_n -> hsync_out follows hsync_in delayed exactly 3 clk.
- Address map: latch xpos=100, ypos=50, then drive hcount=147, vcount=113 -> rom_address=3071 one clk later; hcount=100, vcount=50 -> 0; hcount=99 -> 0 with in_box false.
- Transparency: ROM model returns 12'hF0F inside the box -> rgb_out = rgb_in of 3 clk earlier. ROM returns 12'h0A0 -> rgb_out=12'h0A0.
- Frame latch: change xpos 100→200 and skin_in 0→2 at vcount=300 -> no movement and character_skin stays 0 until hcount=vcount=0, then x_l=200 and character_skin=2.
- Clipping: xpos=620, ypos=0 -> drawing only for hcount 620..639; rom_address never ≥3072; xpos=2040 -> nothing drawn.
- DRAW_CHAR_BBOX_EN build: xpos=100, ypos=50 -> pixels (100,50), (147,80), (120,113) show 12'hFFF; (120,80) shows the sprite.

Source files
------------

// File: rtl/draw_character.sv
// -----------------------------------------------------------------------------
// draw_character
//
// Overlays the CHAR_W x CHAR_H player sprite onto the VGA pixel stream.
// Sprite position and skin are sampled once per frame, at the (0,0) pixel, so
// the sprite never tears mid-frame. The module drives the sprite ROM address
// and the skin select, then takes the ROM's registered colour one clock later.
// The VGA timing is delayed so that it stays aligned with that colour. Every
// *_out signal lags the matching *_in signal by exactly 3 clocks.
//
// Optional build macro: DRAW_CHAR_BBOX_EN
//   When this macro is defined, the perimeter of the sprite rectangle is drawn
//   in BBOX_RGB. This overrides both the sprite colour and transparency. It
//   does not override blanking.
//
// Ports:
//   clk             pixel clock
//   rst_n           asynchronous active-low reset
//   xpos, ypos      sprite top-left corner (screen pixels), latched per frame
//   skin_in         requested skin code, latched per frame
//   hcount_in       horizontal pixel counter from the upstream stage
//   vcount_in       vertical pixel counter from the upstream stage
//   hsync_in, vsync_in, hblnk_in, vblnk_in   VGA timing from upstream
//   rgb_in          background pixel
//   rom_rgb         sprite ROM data, valid 1 clk after rom_address
//   rom_address     sprite ROM read address
//   character_skin  frame-stable skin select for the ROM
//   hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out
//                   timing delayed by 3 clk
//   rgb_out         composited pixel
// -----------------------------------------------------------------------------
module draw_character #(
  parameter int          CHAR_W      = 48,
  parameter int          CHAR_H      = 64,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
`ifdef DRAW_CHAR_BBOX_EN
  ,
  parameter logic [11:0] BBOX_RGB    = 12'hFFF
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [2:0]  skin_in,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] rom_rgb,
  output logic [11:0] rom_address,
  output logic [2:0]  character_skin,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Frame-latched sprite position and skin
  logic [10:0] x_l, y_l;
  logic [2:0]  skin_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l    <= '0;
      y_l    <= '0;
      skin_l <= '0;
    end else if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
      x_l    <= xpos;
      y_l    <= ypos;
      skin_l <= skin_in;
    end
  end

  assign character_skin = skin_l;

  // Stage-1 combinational: box test and sprite-relative offsets.
  // The box compare is done at 12 bits. As a result, x_l + CHAR_W near the
  // top of the 11-bit range cannot wrap around and hit low hcount values.
  logic [10:0] dx, dy;
  logic [11:0] h_ext, v_ext, x_end, y_end;
  logic        in_box;
  logic [11:0] addr_next;

  always_comb begin
    dx        = hcount_in - x_l;
    dy        = vcount_in - y_l;
    h_ext     = {1'b0, hcount_in};
    v_ext     = {1'b0, vcount_in};
    x_end     = {1'b0, x_l} + 12'(CHAR_W);
    y_end     = {1'b0, y_l} + 12'(CHAR_H);
    in_box    = (h_ext >= {1'b0, x_l}) && (h_ext < x_end) &&
                (v_ext >= {1'b0, y_l}) && (v_ext < y_end);
    // Constant multiply: this reduces to shift-and-add
    // (dy*32 + dy*16 for width 48).
    addr_next = in_box ? (({1'b0, dy} * 12'(CHAR_W)) + {1'b0, dx}) : 12'd0;
  end

`ifdef DRAW_CHAR_BBOX_EN
  logic perim, perim_d1, perim_d2;
  assign perim = in_box && (dx == 11'd0 || dx == 11'(CHAR_W - 1) ||
                            dy == 11'd0 || dy == 11'(CHAR_H - 1));
`endif

  // Pipeline registers. The d2 stage lines up with rom_rgb.
  logic [10:0] hcount_d1, vcount_d1, hcount_d2, vcount_d2;
  logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
  logic        hsync_d2, vsync_d2, hblnk_d2, vblnk_d2;
  logic [11:0] rgb_d1, rgb_d2;
  logic        in_box_d1, in_box_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_address <= '0;
      hcount_d1   <= '0;  vcount_d1 <= '0;
      hsync_d1    <= 1'b0; vsync_d1  <= 1'b0;
      hblnk_d1    <= 1'b0; vblnk_d1  <= 1'b0;
      rgb_d1      <= '0;  in_box_d1 <= 1'b0;
      hcount_d2   <= '0;  vcount_d2 <= '0;
      hsync_d2    <= 1'b0; vsync_d2  <= 1'b0;
      hblnk_d2    <= 1'b0; vblnk_d2  <= 1'b0;
      rgb_d2      <= '0;  in_box_d2 <= 1'b0;
      hcount_out  <= '0;  vcount_out <= '0;
      hsync_out   <= 1'b0; vsync_out  <= 1'b0;
      hblnk_out   <= 1'b0; vblnk_out  <= 1'b0;
      rgb_out     <= '0;
    end else begin
      // stage 1
      rom_address <= addr_next;
      hcount_d1   <= hcount_in;  vcount_d1 <= vcount_in;
      hsync_d1    <= hsync_in;   vsync_d1  <= vsync_in;
      hblnk_d1    <= hblnk_in;   vblnk_d1  <= vblnk_in;
      rgb_d1      <= rgb_in;     in_box_d1 <= in_box;
      // stage 2 (ROM access)
      hcount_d2   <= hcount_d1;  vcount_d2 <= vcount_d1;
      hsync_d2    <= hsync_d1;   vsync_d2  <= vsync_d1;
      hblnk_d2    <= hblnk_d1;   vblnk_d2  <= vblnk_d1;
      rgb_d2      <= rgb_d1;     in_box_d2 <= in_box_d1;
      // stage 3 (output register)
      hcount_out  <= hcount_d2;  vcount_out <= vcount_d2;
      hsync_out   <= hsync_d2;   vsync_out  <= vsync_d2;
      hblnk_out   <= hblnk_d2;   vblnk_out  <= vblnk_d2;
`ifdef DRAW_CHAR_BBOX_EN
      if (perim_d2 && !hblnk_d2 && !vblnk_d2)
        rgb_out <= BBOX_RGB;
      else
`endif
      if (in_box_d2 && rom_rgb != TRANSPARENT && !hblnk_d2 && !vblnk_d2)
        rgb_out <= rom_rgb;
      else
        rgb_out <= rgb_d2;
    end
  end

`ifdef DRAW_CHAR_BBOX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perim_d1 <= 1'b0;
      perim_d2 <= 1'b0;
    end else begin
      perim_d1 <= perim;
      perim_d2 <= perim_d1;
    end
  end
`endif

endmodule

// File: tb/tb_draw_character.sv
// -----------------------------------------------------------------------------
// tb_draw_character
//
// Scoreboard bench for draw_character. Each driven pixel pushes its expected
// outputs. The expected 3-clk outputs are popped once the pipeline has had
// time to deliver them. A behavioural registered ROM supplies the sprite
// colours.
// -----------------------------------------------------------------------------
module tb_draw_character;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [2:0]  skin_in = '0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] rom_rgb = '0;
  logic [11:0] rom_address;
  logic [2:0]  character_skin;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_character dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .skin_in(skin_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_rgb(rom_rgb), .rom_address(rom_address),
    .character_skin(character_skin),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents. Addresses whose low bits are 3 read as transparent.
  // Every other colour has its top bit clear, so it can never equal 12'hF0F.
  function automatic logic [11:0] rom_func(input logic [11:0] a);
    if (a[2:0] == 3'd3) return 12'hF0F;
    return {1'b0, a[10:0]} ^ 12'h2A5;
  endfunction

  always @(posedge clk) rom_rgb <= rom_func(rom_address);

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t        out_q[$];
  logic [11:0] addr_q[$];
  int          x_m, y_m;
  logic [2:0]  skin_m;
  int          tests = 0, failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, record its expectations, advance one clock and compare.
  task automatic px(input int h, input int v, input bit hb = 1'b0, input bit vb = 1'b0);
    exp_t        e;
    bit          inb, perim;
    int          addr;
    logic [11:0] rom;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = 12'($urandom);
    inb   = (h >= x_m) && (h < x_m + 48) && (v >= y_m) && (v < y_m + 64);
    addr  = inb ? (((v - y_m) * 48 + (h - x_m)) % 4096) : 0;
    perim = inb && ((h - x_m) == 0 || (h - x_m) == 47 || (v - y_m) == 0 || (v - y_m) == 63);
    rom   = rom_func(12'(addr));
    e.h = hcount_in; e.v = vcount_in;
    e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
    e.rgb = rgb_in;
    if (!hb && !vb) begin
      if (inb && rom != 12'hF0F) e.rgb = rom;
`ifdef DRAW_CHAR_BBOX_EN
      if (perim) e.rgb = 12'hFFF;
`endif
    end
    out_q.push_back(e);
    addr_q.push_back(12'(addr));
    @(posedge clk);
    #1;
    if (h == 0 && v == 0) begin
      x_m = int'(xpos); y_m = int'(ypos); skin_m = skin_in;
    end
    check_eq("rom_address", {20'd0, rom_address}, {20'd0, addr_q.pop_front()});
    check_eq("addr_range", {31'd0, rom_address < 12'd3072}, 32'd1);
    check_eq("character_skin", {29'd0, character_skin}, {29'd0, skin_m});
    if (out_q.size() >= 3) begin
      e = out_q.pop_front();
      check_eq("timing_out", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
               {6'd0, e.h, e.v, e.hs, e.vs, e.hb, e.vb});
      check_eq("rgb_out", {20'd0, rgb_out}, {20'd0, e.rgb});
    end
    $display("[TB] pixel h=%0d v=%0d addr=%0d skin=%0d rgb_out=%03h", h, v, rom_address, character_skin, rgb_out);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_a"}, {5'd0, rom_address, character_skin, rgb_out}, 32'd0);
    check_eq({tag, "_b"}, {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
  endtask

  // Asynchronous reset entered mid-cycle, held with random inputs, then released.
  task automatic do_reset();
    exp_t z;
    z = '{h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    for (int i = 0; i < 3; i++) begin
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      xpos = 11'($urandom); ypos = 11'($urandom); skin_in = 3'($urandom);
      hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
      rgb_in = 12'($urandom);
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    $display("[TB] reset held, outputs rgb=%03h hcount=%0d", rgb_out, hcount_out);
    rst_n = 1'b1;
    out_q.delete();
    addr_q.delete();
    // The first two outputs after release come from the flushed pipeline.
    out_q.push_back(z);
    out_q.push_back(z);
    x_m = 0; y_m = 0; skin_m = 3'd0;
  endtask

  initial begin
    do_reset();

    // Latch a sprite at (100,50) with skin 0, then check the address map
    // and compositing.
    xpos = 11'd100; ypos = 11'd50; skin_in = 3'd0;
    px(0, 0);
    px(147, 113);
    px(100, 50);
    px(99, 50);
    for (int h = 98; h < 112; h++) px(h, 60);
    px(120, 80);
    px(147, 80);
    px(120, 113);
    px(103, 50);
    px(110, 70, 1'b1, 1'b0);
    px(110, 70, 1'b0, 1'b1);
    px(147, 114);
    px(148, 113);

    // Mid-frame input changes must not move the sprite until the next frame.
    xpos = 11'd200; skin_in = 3'd2;
    for (int h = 98; h < 104; h++) px(h, 300);
    px(105, 60);
    px(205, 60);
    px(0, 0);
    px(105, 60);
    px(205, 60);
    px(200, 50);
    px(247, 113);

    // Skin code 7 is passed straight through to the ROM.
    skin_in = 3'd7;
    px(0, 0);
    px(210, 70);

    // Right-edge clipping: with hblnk high past column 639, only 620..639 draw.
    xpos = 11'd620; ypos = 11'd0; skin_in = 3'd1;
    px(0, 0);
    for (int h = 615; h < 672; h++) px(h, 10, h >= 640);
    px(625, 63);
    px(625, 64);

    // A position near the top of the counter range must not wrap onto the screen.
    xpos = 11'd2040; ypos = 11'd2040;
    px(0, 0);
    for (int h = 0; h < 12; h++) px(h, 5);
    for (int h = 0; h < 4; h++) px(h, 0);

    // A reset in mid-frame puts the sprite back at (0,0) until the next latch.
    do_reset();
    for (int h = 0; h < 10; h++) px(h, 10);
    px(50, 10);
    for (int i = 0; i < 3; i++) px(700, 500, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard bound, so that a stalled simulation still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
